alu_serial_ctrl: RTL and testbench

- Bit-serial sequencer that drives a single-bit ALU slice over its slice interface: a, b, i3, add_sub, cin and op out; r and co back.
- Accepts WIDTH-bit operands and an operation through a valid/ready request port.
- Issues one bit per clock, LSB first, and carries the slice carry-out forward through a flip-flop.
- Assembles result, carry, overflow and zero, then returns them on a valid/ready response port.

---
 rtl/alu_ser_pkg.sv | 14 +
 rtl/alu_serial_ctrl_if.sv | 28 ++
 rtl/alu_ser_shreg.sv | 24 ++
 rtl/alu_serial_ctrl.sv | 166 ++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/alu_ser_pkg.sv
// Shared constants for the bit-serial ALU sequencer: operation codes and FSM state encoding.
package alu_ser_pkg;

    localparam logic [1:0] OP_AND   = 2'b00;
    localparam logic [1:0] OP_OR    = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_SLT   = 2'b11;

    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] CALC     = 2'b01;
    localparam logic [1:0] SLT_PASS = 2'b10;
    localparam logic [1:0] DONE     = 2'b11;

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response handshake bundle for alu_serial_ctrl.
// The master side issues requests and consumes results; the slave side is the controller.
interface alu_serial_ctrl_if #(parameter int WIDTH = 8);

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_op;
    logic             req_sub;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_ovf;
    logic             rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_op, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_zero
    );

endinterface

// File: rtl/alu_ser_shreg.sv
// WIDTH-bit register with parallel load and right shift (new bit enters at the MSB).
module alu_ser_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             shift_in,
    output logic [WIDTH-1:0] q
);

    // Load wins over shift so a fresh value can replace a shifting one in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (shift)
            q <= {shift_in, q[WIDTH-1:1]};
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving a 1-bit ALU slice, LSB first, with a carry flip-flop between bits.
// Optional macro ALU_SER_FAST_SLT_EN: SLT result is formed directly after the subtract pass.
module alu_serial_ctrl
    import alu_ser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_serial_ctrl_if.slave   bus,
    output logic               slice_a,
    output logic               slice_b,
    output logic               slice_i3,
    output logic               slice_add_sub,
    output logic               slice_cin,
    output logic [1:0]         slice_op,
    input  logic               slice_r,
    input  logic               slice_co
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic             sub_q;
    logic             carry_q;
    logic             cin_msb_q;
    logic             cout_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             accept;
    logic             last;
    logic             in_calc;
    logic             in_slt;
    logic             less_now;
    logic             res_load;
    logic [WIDTH-1:0] res_load_val;
    logic             unused_bits;
`ifndef ALU_SER_FAST_SLT_EN
    logic             less_q;
`endif

    assign accept      = (state == IDLE) && bus.req_valid;
    assign last        = (cnt == CNT_W'(WIDTH - 1));
    assign in_calc     = (state == CALC);
    assign in_slt      = (state == SLT_PASS);
    assign less_now    = slice_r ^ slice_cin ^ slice_co;
    assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};

`ifdef ALU_SER_FAST_SLT_EN
    assign res_load     = accept || (in_calc && last && (op_q == OP_SLT));
    assign res_load_val = accept ? '0 : {{(WIDTH-1){1'b0}}, less_now};
`else
    assign res_load     = accept;
    assign res_load_val = '0;
`endif

    alu_ser_shreg #(.WIDTH(WIDTH)) u_a_reg (
        .clk(clk), .rst_n(rst_n), .load(accept), .load_val(bus.req_a),
        .shift(in_calc), .shift_in(1'b0), .q(a_q)
    );

    alu_ser_shreg #(.WIDTH(WIDTH)) u_b_reg (
        .clk(clk), .rst_n(rst_n), .load(accept), .load_val(bus.req_b),
        .shift(in_calc), .shift_in(1'b0), .q(b_q)
    );

    alu_ser_shreg #(.WIDTH(WIDTH)) u_res_reg (
        .clk(clk), .rst_n(rst_n), .load(res_load), .load_val(res_load_val),
        .shift(in_calc || in_slt), .shift_in(slice_r), .q(res_q)
    );

    // Slice drive: SLT borrows the subtractor in CALC, then uses the i3 path in SLT_PASS.
    always_comb begin
        slice_a       = 1'b0;
        slice_b       = 1'b0;
        slice_i3      = 1'b0;
        slice_add_sub = 1'b0;
        slice_cin     = 1'b0;
        slice_op      = 2'b00;
        if (in_calc) begin
            slice_a       = a_q[0];
            slice_b       = b_q[0];
            slice_op      = (op_q == OP_SLT) ? OP_ARITH : op_q;
            slice_add_sub = (op_q == OP_ARITH) ? sub_q : (op_q == OP_SLT);
            slice_cin     = (cnt == '0) ? slice_add_sub : carry_q;
        end else if (in_slt) begin
            slice_op = OP_SLT;
`ifndef ALU_SER_FAST_SLT_EN
            slice_i3 = (cnt == '0) ? less_q : 1'b0;
`endif
        end
    end

    // Sequencer; MSB carry-in/out are captured on the last CALC bit for the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= OP_AND;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            cin_msb_q   <= 1'b0;
            cout_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifndef ALU_SER_FAST_SLT_EN
            less_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= bus.req_op;
                        sub_q   <= bus.req_sub;
                        cnt     <= '0;
                        carry_q <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    carry_q <= slice_co;
                    if (last) begin
                        cnt       <= '0;
                        cin_msb_q <= slice_cin;
                        cout_q    <= slice_co;
`ifdef ALU_SER_FAST_SLT_EN
                        state     <= DONE;
`else
                        less_q    <= less_now;
                        state     <= (op_q == OP_SLT) ? SLT_PASS : DONE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SLT_PASS: begin
                    if (last) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_valid_q ? res_q : '0;
    assign bus.rsp_carry  = rsp_valid_q && (op_q == OP_ARITH) && cout_q;
    assign bus.rsp_ovf    = rsp_valid_q && (op_q == OP_ARITH) && (cin_msb_q ^ cout_q);
    assign bus.rsp_zero   = rsp_valid_q && (res_q == '0);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl with a behavioural 1-bit ALU slice attached.
module tb_alu_serial_ctrl;
    import alu_ser_pkg::*;

    localparam int WIDTH   = 8;
    localparam int ADD_LAT = 9;
`ifdef ALU_SER_FAST_SLT_EN
    localparam int SLT_LAT = 9;
`else
    localparam int SLT_LAT = 17;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       slice_a, slice_b, slice_i3, slice_add_sub, slice_cin;
    logic [1:0] slice_op;
    logic       slice_r, slice_co, bx;
    int         total = 0;
    int         bad = 0;
    int         lat;

    alu_serial_ctrl_if #(.WIDTH(WIDTH)) bus();

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .slice_a(slice_a),
        .slice_b(slice_b),
        .slice_i3(slice_i3),
        .slice_add_sub(slice_add_sub),
        .slice_cin(slice_cin),
        .slice_op(slice_op),
        .slice_r(slice_r),
        .slice_co(slice_co)
    );

    always #5 clk = ~clk;

    // Classic 1-bit ALU slice: AND, OR, full adder with optional B inversion, pass-through of i3.
    always_comb begin
        bx       = slice_b ^ slice_add_sub;
        slice_co = (slice_a & bx) | (slice_a & slice_cin) | (bx & slice_cin);
        case (slice_op)
            2'b00:   slice_r = slice_a & slice_b;
            2'b01:   slice_r = slice_a | slice_b;
            2'b10:   slice_r = slice_a ^ bx ^ slice_cin;
            default: slice_r = slice_i3;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic sub, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        checkOutput("accept_ready", bus.req_ready, 1);
        bus.req_op    = op;
        bus.req_sub   = sub;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic waitResponse(output int cycles);
        int k;
        cycles = -1;
        k = 0;
        while (cycles < 0 && k < 40) begin
            k++;
            @(posedge clk);
            #1;
            if (k == 1) checkOutput("busy_ready", bus.req_ready, 0);
            if (bus.rsp_valid) cycles = k;
        end
    endtask

    task automatic finishRsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        checkOutput({tag, "_hs_valid"}, bus.rsp_valid, 0);
        checkOutput({tag, "_hs_ready"}, bus.req_ready, 1);
    endtask

    task automatic runOp(input string tag, input logic [1:0] op, input logic sub,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] expRes,
                         input logic expC, input logic expV, input logic expZ, input int expLat);
        int cycles;
        applyStimulus(op, sub, a, b);
        waitResponse(cycles);
        checkOutput({tag, "_lat"}, cycles, expLat);
        checkOutput({tag, "_res"}, bus.rsp_result, expRes);
        checkOutput({tag, "_carry"}, bus.rsp_carry, expC);
        checkOutput({tag, "_ovf"}, bus.rsp_ovf, expV);
        checkOutput({tag, "_zero"}, bus.rsp_zero, expZ);
        checkOutput({tag, "_slice_op"}, slice_op, 0);
        finishRsp(tag);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = 2'b00;
        bus.req_sub   = 1'b0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", bus.req_ready, 1);
        checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("rst_rsp_result", bus.rsp_result, 0);
        checkOutput("rst_rsp_flags", {bus.rsp_carry, bus.rsp_ovf, bus.rsp_zero}, 0);
        checkOutput("rst_slice", {slice_a, slice_b, slice_i3, slice_add_sub, slice_cin, slice_op}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("add_7f_01", OP_ARITH, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, ADD_LAT);
        runOp("add_ff_01", OP_ARITH, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, ADD_LAT);
        runOp("sub_05_07", OP_ARITH, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, ADD_LAT);
        runOp("sub_07_07", OP_ARITH, 1'b1, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1, ADD_LAT);
        runOp("slt_80_01", OP_SLT,   1'b0, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, SLT_LAT);
        runOp("slt_01_80", OP_SLT,   1'b0, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, SLT_LAT);
        runOp("and_f0_3c", OP_AND,   1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, ADD_LAT);
        runOp("or_f0_3c",  OP_OR,    1'b0, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, ADD_LAT);

        // Back-pressure: result must hold and a pending request must wait for the handshake.
        applyStimulus(OP_ARITH, 1'b0, 8'h12, 8'h34);
        waitResponse(lat);
        checkOutput("hold_lat", lat, ADD_LAT);
        @(negedge clk);
        bus.req_a     = 8'h01;
        bus.req_b     = 8'h01;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", bus.rsp_valid, 1);
            checkOutput("hold_result", bus.rsp_result, 8'h46);
            checkOutput("hold_req_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        checkOutput("hold_hs_valid", bus.rsp_valid, 0);
        checkOutput("hold_hs_ready", bus.req_ready, 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        checkOutput("second_accepted", bus.req_ready, 0);
        waitResponse(lat);
        checkOutput("second_lat", lat - 1, ADD_LAT - 1);
        checkOutput("second_result", bus.rsp_result, 8'h02);
        finishRsp("second");

        // Reset in the middle of CALC discards the partial result.
        applyStimulus(OP_ARITH, 1'b1, 8'h33, 8'h11);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_rsp_valid", bus.rsp_valid, 0);
        checkOutput("abort_req_ready", bus.req_ready, 1);
        checkOutput("abort_slice_op", slice_op, 0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("after_abort", OP_ARITH, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0, ADD_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
